// File: rtl/filt_pack_pkg.sv
// Shared types and helpers for the filtered-sample packer: lane/word widths, FIFO entry, sign extension.
// Pure definitions, no latency or flow control of its own.
package filt_pack_pkg;

   localparam int LANE_W = 16;
   localparam int WORD_W = 32;

   typedef struct packed {
      logic              tlast;
      logic [WORD_W-1:0] tdata;
   } fifo_entry_t;

   // Replicates bit (width-1) of raw into every lane bit above it.
   function automatic logic [LANE_W-1:0] sext_lane(input logic [LANE_W-1:0] raw, input int width);
      logic [LANE_W-1:0]         res;
      logic [$clog2(LANE_W)-1:0] msb;
      msb = $clog2(LANE_W)'(width - 1);
      for (int i = 0; i < LANE_W; i++) begin
         res[i] = (i < width) ? raw[i] : raw[msb];
      end
      return res;
   endfunction

endpackage

// File: rtl/packer_fifo.sv
// Word FIFO with a registered head; a write into an empty FIFO shows on rd_vld one cycle later.
// Backpressure: caller gates wr_vld with full; a push while the sole head word pops bypasses straight into the head.
module packer_fifo
   import filt_pack_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_vld,
   input  fifo_entry_t wr_dat,
   output logic        full,
   output logic        rd_vld,
   input  logic        rd_rdy,
   output fifo_entry_t rd_dat
);

   localparam int AW = $clog2(DEPTH);

   fifo_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   mem_cnt;
   logic [AW:0]   total;
   logic          pop;
   logic          refill;
   logic          bypass;
   logic          mem_wr;

   // Capacity counts the head register as well as the array.
   always_comb begin
      pop    = rd_vld && rd_rdy;
      refill = (mem_cnt != '0) && (!rd_vld || pop);
      bypass = wr_vld && pop && (mem_cnt == '0);
      mem_wr = wr_vld && !bypass;
      total  = mem_cnt + (AW + 1)'(rd_vld);
      full   = (total == (AW + 1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_vld  <= 1'b0;
         rd_dat  <= '0;
      end else begin
         if (mem_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (refill) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({mem_wr, refill})
            2'b10:   mem_cnt <= mem_cnt + (AW + 1)'(1);
            2'b01:   mem_cnt <= mem_cnt - (AW + 1)'(1);
            default: mem_cnt <= mem_cnt;
         endcase
         if (refill) begin
            rd_dat <= mem[rd_ptr];
         end else if (bypass) begin
            rd_dat <= wr_dat;
         end
         if (refill || bypass) begin
            rd_vld <= 1'b1;
         end else if (pop) begin
            rd_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/filt_sample_packer.sv
// Decimates filtered ADC samples, sign-extends to 16 bits and packs two per AXI-Stream word with framing.
// Latency: second sample of a pair -> tvalid after 3 edges; tready stall fills the FIFO, then words drop with sticky overflow.
module filt_sample_packer
   import filt_pack_pkg::*;
#(
   parameter int ADC_WIDTH        = 14,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int DECIM            = 1,
   parameter int FRAME_LEN        = 256,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [ADC_WIDTH-1:0]        adc_filt_a,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        overflow
);

   logic [ADC_WIDTH-1:0] s0_dat;
   logic                 s0_en;
   logic [15:0]          dcnt;
   logic                 ph;
   logic [LANE_W-1:0]    lane_lo;
   logic [15:0]          fcnt;
   logic [LANE_W-1:0]    raw;
   logic [LANE_W-1:0]    lane_new;
   logic                 accept;
   logic                 word_done;
   logic                 frame_end;
   logic                 pop;
   logic                 wr_ok;
   logic                 fifo_full;
   fifo_entry_t          wr_dat;
   fifo_entry_t          rd_dat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_dat <= '0;
         s0_en  <= 1'b0;
      end else begin
         s0_dat <= adc_filt_a;
         s0_en  <= enable;
      end
   end

   // A full FIFO still takes the word when its head pops in the same cycle.
   always_comb begin
      raw                  = '0;
      raw[ADC_WIDTH-1:0]   = s0_dat;
      lane_new             = sext_lane(raw, ADC_WIDTH);
      accept               = s0_en && (dcnt == 16'd0);
      word_done            = accept && ph;
      frame_end            = (fcnt == 16'(FRAME_LEN - 1));
      pop                  = m_axis_tvalid && m_axis_tready;
      wr_ok                = word_done && (!fifo_full || pop);
      wr_dat.tdata         = {lane_new, lane_lo};
      wr_dat.tlast         = frame_end;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt     <= '0;
         ph       <= 1'b0;
         lane_lo  <= '0;
         fcnt     <= '0;
         overflow <= 1'b0;
      end else begin
         if (!s0_en) begin
            dcnt <= '0;
            ph   <= 1'b0;
         end else begin
            dcnt <= (dcnt == 16'(DECIM - 1)) ? 16'd0 : dcnt + 16'd1;
            if (accept) begin
               ph <= ~ph;
            end
         end
         if (accept && !ph) begin
            lane_lo <= lane_new;
         end
         // Frame position tracks delivered words only, so drops never shorten a frame.
         if (wr_ok) begin
            fcnt <= frame_end ? 16'd0 : fcnt + 16'd1;
         end
         if (word_done && !wr_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   packer_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (reset),
      .wr_vld (wr_ok),
      .wr_dat (wr_dat),
      .full   (fifo_full),
      .rd_vld (m_axis_tvalid),
      .rd_rdy (m_axis_tready),
      .rd_dat (rd_dat)
   );

   assign m_axis_tdata = rd_dat.tdata;
   assign m_axis_tlast = rd_dat.tlast;

endmodule

// File: tb/tb_filt_sample_packer.sv
// Directed bench for filt_sample_packer: one DECIM=1 and one DECIM=3 instance share the input stream.
// Words are collected at negedge whenever a transfer is about to happen and compared against expected lists.
module tb_filt_sample_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [13:0] adc = '0;
   logic        tready = 1'b0;

   logic [31:0] a_tdata;
   logic        a_tvalid;
   logic        a_tlast;
   logic        a_ovf;
   logic [31:0] b_tdata;
   logic        b_tvalid;
   logic        b_tlast;
   logic        b_ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [32:0] qa[$];
   logic [32:0] qb[$];
   logic [32:0] exp_q[$];

   logic meas_en = 1'b0;
   logic got_first = 1'b0;
   int   first_cyc = 0;
   logic stall_chk = 1'b0;
   int   stall_bad = 0;
   int   stall_n = 0;

   typedef struct {
      logic [13:0] a0;
      logic [13:0] a1;
      logic [31:0] word;
   } vec_t;
   vec_t tbl[8];

   filt_sample_packer #(
      .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .DECIM(1), .FRAME_LEN(4), .FIFO_DEPTH(16)
   ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .adc_filt_a(adc),
      .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
      .m_axis_tlast(a_tlast), .overflow(a_ovf)
   );

   filt_sample_packer #(
      .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .DECIM(3), .FRAME_LEN(4), .FIFO_DEPTH(16)
   ) u_dec (
      .clk(clk), .reset(reset), .enable(enable), .adc_filt_a(adc),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
      .m_axis_tlast(b_tlast), .overflow(b_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && a_tvalid && tready) qa.push_back({a_tlast, a_tdata});
      if (!reset && b_tvalid && tready) qb.push_back({b_tlast, b_tdata});
      if (meas_en && a_tvalid && !got_first) begin
         got_first = 1'b1;
         first_cyc = cyc;
      end
      if (stall_chk && a_tvalid) begin
         stall_n++;
         if (a_tdata !== 32'h0001_0000 || a_tlast !== 1'b0) stall_bad++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_stream(input string nm, input bit use_b, input int base);
      int n;
      n = use_b ? qb.size() : qa.size();
      chk({nm, "_count"}, 64'(n - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < n)
            chk($sformatf("%s_word%0d", nm, i), 64'(use_b ? qb[base + i] : qa[base + i]), 64'(exp_q[i]));
      end
   endtask

   function automatic logic [32:0] mk(input logic tl, input int lo, input int hi);
      logic [13:0] l;
      logic [13:0] h;
      l = 14'(lo);
      h = 14'(hi);
      return {tl, {2{h[13]}}, h, {2{l[13]}}, l};
   endfunction

   task automatic drive(input logic en, input logic [13:0] s);
      @(posedge clk);
      #1;
      enable = en;
      adc = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 14'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      enable = 1'b0;
      adc = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int base;
      int base_b;
      int drv_cyc;

      tbl[0] = '{14'd0,    14'd1,    32'h0001_0000};
      tbl[1] = '{14'd2,    14'd3,    32'h0003_0002};
      tbl[2] = '{14'h3FFF, 14'h2000, 32'hE000_FFFF};
      tbl[3] = '{14'h1FFF, 14'h2000, 32'hE000_1FFF};
      tbl[4] = '{14'h3FFE, 14'd5,    32'h0005_FFFE};
      tbl[5] = '{14'd100,  14'h3F9C, 32'hFF9C_0064};
      tbl[6] = '{14'h2001, 14'h1000, 32'h1000_E001};
      tbl[7] = '{14'd0,    14'h3FFF, 32'hFFFF_0000};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tvalid", 64'(a_tvalid), 64'd0);
      chk("rst_tlast", 64'(a_tlast), 64'd0);
      chk("rst_tdata", 64'(a_tdata), 64'd0);
      chk("rst_overflow", 64'(a_ovf), 64'd0);
      chk("rst_tvalid_dec", 64'(b_tvalid), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Table vectors, streamed back to back, with first-word latency
      tready = 1'b1;
      base = qa.size();
      meas_en = 1'b1;
      drive(1'b1, tbl[0].a0);
      drive(1'b1, tbl[0].a1);
      drv_cyc = cyc;
      for (int i = 1; i < 8; i++) begin
         drive(1'b1, tbl[i].a0);
         drive(1'b1, tbl[i].a1);
      end
      idle(12);
      meas_en = 1'b0;
      chk("first_tvalid_latency", got_first ? 64'(first_cyc - drv_cyc) : 64'hFFFF, 64'd3);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back({(i % 4 == 3) ? 1'b1 : 1'b0, tbl[i].word});
      chk_stream("table", 1'b0, base);
      chk("table_overflow", 64'(a_ovf), 64'd0);

      // Ramp: DECIM=1 packs pairs, DECIM=3 packs every third sample
      do_reset();
      base = qa.size();
      base_b = qb.size();
      for (int k = 0; k < 48; k++) drive(1'b1, 14'(k));
      idle(20);
      exp_q.delete();
      for (int k = 0; k < 24; k++) exp_q.push_back(mk(k % 4 == 3, 2 * k, 2 * k + 1));
      chk_stream("ramp", 1'b0, base);
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back(mk(k % 4 == 3, 6 * k, 6 * k + 3));
      chk_stream("decim3", 1'b1, base_b);
      chk("ramp_overflow", 64'(a_ovf), 64'd0);

      // Stall: fill FIFO, push during a single pop, then overflow
      do_reset();
      tready = 1'b0;
      base = qa.size();
      stall_chk = 1'b1;
      for (int k = 0; k < 32; k++) drive(1'b1, 14'(k));
      idle(6);
      chk("full_no_ovf_yet", 64'(a_ovf), 64'd0);
      chk("full_tvalid", 64'(a_tvalid), 64'd1);
      drive(1'b1, 14'd32);
      drive(1'b1, 14'd33);
      @(posedge clk);
      #1;
      enable = 1'b0;
      tready = 1'b1;
      stall_chk = 1'b0;
      @(posedge clk);
      #1;
      tready = 1'b0;
      @(negedge clk);
      chk("push_pop_full_no_ovf", 64'(a_ovf), 64'd0);
      drive(1'b1, 14'd34);
      drive(1'b1, 14'd35);
      idle(4);
      @(negedge clk);
      chk("overflow_set", 64'(a_ovf), 64'd1);
      chk("stall_tdata_stable", 64'(stall_bad), 64'd0);
      chk("stall_observed", 64'(stall_n >= 20), 64'd1);
      @(posedge clk);
      #1;
      tready = 1'b1;
      idle(40);
      for (int k = 36; k < 44; k++) drive(1'b1, 14'(k));
      idle(20);
      exp_q.delete();
      for (int k = 0; k < 17; k++) exp_q.push_back(mk(k % 4 == 3, 2 * k, 2 * k + 1));
      for (int j = 0; j < 4; j++) exp_q.push_back(mk((17 + j) % 4 == 3, 2 * (18 + j), 2 * (18 + j) + 1));
      chk_stream("stall", 1'b0, base);
      chk("overflow_sticky", 64'(a_ovf), 64'd1);

      // Enable dropped mid-pair; frame position kept
      do_reset();
      tready = 1'b1;
      base = qa.size();
      drive(1'b1, 14'd1);
      drive(1'b1, 14'd2);
      drive(1'b1, 14'd5);
      drive(1'b0, 14'd6);
      drive(1'b0, 14'd7);
      for (int k = 200; k < 206; k++) drive(1'b1, 14'(k));
      idle(15);
      exp_q.delete();
      exp_q.push_back({1'b0, 32'h0002_0001});
      exp_q.push_back({1'b0, 32'h00C9_00C8});
      exp_q.push_back({1'b0, 32'h00CB_00CA});
      exp_q.push_back({1'b1, 32'h00CD_00CC});
      chk_stream("enable_gap", 1'b0, base);

      // Reset asserted during a full stall
      do_reset();
      tready = 1'b0;
      for (int k = 0; k < 40; k++) drive(1'b1, 14'(k));
      idle(4);
      @(negedge clk);
      chk("pre_reset_overflow", 64'(a_ovf), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      chk("midrst_tvalid", 64'(a_tvalid), 64'd0);
      chk("midrst_overflow", 64'(a_ovf), 64'd0);
      chk("midrst_tdata", 64'(a_tdata), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tready = 1'b1;
      base = qa.size();
      drive(1'b1, 14'd7);
      drive(1'b1, 14'd8);
      idle(10);
      exp_q.delete();
      exp_q.push_back({1'b0, 32'h0008_0007});
      chk_stream("after_reset", 1'b0, base);
      chk("after_reset_overflow", 64'(a_ovf), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
